// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch queue.
//
// Holds the filler instruction, the addi x1,x0,imm encoding used to build the
// instruction ROM image, and the {pc, instr} entry carried through the queue.
package fetch_pkg;

  // addi x0,x0,0: the canonical RISC-V nop, used as filler.
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

  // addi x1,x0,0 with the 12-bit immediate field starting at bit 20.
  localparam logic [31:0] ADDI_X1_X0_BASE = 32'h0000_0093;
  localparam int unsigned ADDI_IMM_LSB    = 20;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Encoding of addi x1,x0,imm for a word index that fits the immediate.
  function automatic logic [31:0] addi_x1_imm(input logic [31:0] imm);
    return ADDI_X1_X0_BASE | (imm << ADDI_IMM_LSB);
  endfunction

endpackage

// File: rtl/instr_rom.sv
// Purely combinational instruction ROM.
//
// Word i holds addi x1,x0,i. Any byte address at or beyond ROM_WORDS*4 reads
// back the filler instruction.
//
// Ports:
//   addr  [31:0] in   byte address; word index is addr >> 2
//   instr [31:0] out  instruction word at that address
module instr_rom
  import fetch_pkg::*;
#(
  parameter int unsigned ROM_WORDS = 32,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic [31:0] addr,
  output logic [31:0] instr
);

  // 33 bits so ROM_WORDS*4 never wraps for large parameter values.
  localparam logic [32:0] ROM_BYTES = 33'(ROM_WORDS) * 33'd4;

  logic [31:0] word_idx;

  always_comb begin
    word_idx = addr >> 2;
    instr    = NOP_INSTR;
    if ({1'b0, addr} < ROM_BYTES) begin
      instr = addi_x1_imm(word_idx);
    end
  end

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction fetch queue: looks up each fetch request in the instruction ROM
// and buffers {pc, instr} pairs for the decode stage.
//
// Ports:
//   clk           in   clock, rising edge
//   rst           in   asynchronous active-high reset
//   pc     [31:0] in   fetch address
//   pc_valid      in   pc is a fetch request this cycle
//   full          out  queue holds DEPTH entries (stall hint upstream)
//   flush         in   discard every queued entry at the next edge
//   out_valid     out  head entry available
//   out_ready     in   consumer accepts the head entry
//   out_pc [31:0] out  pc of the head entry
//   out_instr[31:0] out instruction of the head entry
//   misalign_err  out  one-cycle pulse after a push with pc[1:0] != 0
//   overflow      out  sticky: a request was dropped because the queue was full
//
// Handshake: the output side is a strict valid/ready channel. out_valid never
// depends on out_ready; a transfer happens on every rising edge where both are
// high, and while out_valid=1 and out_ready=0 the head payload is held stable.
// The input side has no ready: a request arriving while full with no pop is
// dropped and recorded in overflow, so upstream should stall on full.
module if_fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned ROM_WORDS = 32,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        pc_valid,
  output logic        full,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        misalign_err,
  output logic        overflow
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  // Storage is deliberately left unreset; count and pointers qualify it.
  fetch_entry_t mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             misalign_q, misalign_d;
  fetch_entry_t     head_q, head_d;

  logic         handshake;
  logic         push;
  logic         pop;
  logic         drop;
  logic         misaligned;
  logic [31:0]  rom_instr;
  fetch_entry_t push_entry;

  instr_rom #(
    .ROM_WORDS (ROM_WORDS),
    .NOP_INSTR (NOP_INSTR)
  ) u_rom (
    .addr  (pc),
    .instr (rom_instr)
  );

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  // Flags are decoded from the registered count only.
  assign full      = (count_q == CNT_FULL);
  assign out_valid = (count_q != '0);

  assign out_pc       = head_q.pc;
  assign out_instr    = head_q.instr;
  assign misalign_err = misalign_q;
  assign overflow     = overflow_q;

  always_comb begin
    handshake  = out_valid && out_ready;
    misaligned = (pc[1:0] != 2'b00);

    // A push may take a full queue's slot only when the head leaves this cycle.
    pop  = handshake && !flush;
    push = pc_valid && !flush && (!full || handshake);
    drop = pc_valid && !flush && full && !handshake;

    push_entry.pc    = pc;
    push_entry.instr = misaligned ? NOP_INSTR : rom_instr;

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | drop;
    misalign_d = push && misaligned;
    head_d     = head_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase

      // Register the entry that will be at the head after this edge. If that
      // slot is the one being written now (empty queue, or the only entry
      // popped), the incoming entry bypasses storage into the output register.
      if (count_d != '0) begin
        if (push && (wr_ptr_q == rd_ptr_d)) begin
          head_d = push_entry;
        end else begin
          head_d = mem[rd_ptr_d];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      misalign_q   <= 1'b0;
      head_q.pc    <= '0;
      head_q.instr <= NOP_INSTR;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      misalign_q <= misalign_d;
      head_q     <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= push_entry;
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: directed scenarios plus a short mixed stretch,
// checked every cycle against a queue-level model of the fetch queue.
module tb_if_fetch_queue;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic        pc_valid;
  logic        full;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        misalign_err;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  if_fetch_queue #(
    .DEPTH     (DEPTH),
    .ROM_WORDS (32),
    .NOP_INSTR (NOP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pc           (pc),
    .pc_valid     (pc_valid),
    .full         (full),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pc       (out_pc),
    .out_instr    (out_instr),
    .misalign_err (misalign_err),
    .overflow     (overflow)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Queue of {pc, instr}; overflow flag; misalign pulse expected this cycle.
  logic [63:0] exp_q[$];
  logic        exp_ovf = 1'b0;
  logic        exp_mis = 1'b0;

  function automatic logic [31:0] model_instr(input logic [31:0] a);
    if (a[1:0] != 2'b00) return NOP;
    if (a >= 32'd128)    return NOP;
    return 32'h0000_0093 | ((a >> 2) << 20);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      exp_ovf = 1'b0;
      exp_mis = 1'b0;
    end else begin
      bit m_pop, m_push, m_drop;
      m_pop  = (exp_q.size() != 0) && out_ready && !flush;
      m_push = pc_valid && !flush && ((exp_q.size() < DEPTH) || m_pop);
      m_drop = pc_valid && !flush && (exp_q.size() == DEPTH) && !m_pop;
      if (flush) exp_q.delete();
      if (m_pop) void'(exp_q.pop_front());
      if (m_push) exp_q.push_back({pc, model_instr(pc)});
      if (m_drop) exp_ovf = 1'b1;
      exp_mis = m_push && (pc[1:0] != 2'b00);
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
    check("full", 64'(full), 64'(exp_q.size() == DEPTH));
    check("misalign_err", 64'(misalign_err), 64'(exp_mis));
    check("overflow", 64'(overflow), 64'(exp_ovf));
    if (exp_q.size() != 0) begin
      check("head", {out_pc, out_instr}, exp_q[0]);
    end
  end

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic rdy, input logic fl);
    pc_valid  = v;
    pc        = a;
    out_ready = rdy;
    flush     = fl;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_full"}, 64'(full), 64'd0);
    check({tag, "_out_pc"}, 64'(out_pc), 64'd0);
    check({tag, "_out_instr"}, 64'(out_instr), 64'(NOP));
    check({tag, "_misalign"}, 64'(misalign_err), 64'd0);
    check({tag, "_overflow"}, 64'(overflow), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    step();
    step();
    check_reset_values("reset");
    rst = 1'b0;

    // Single fetch of pc=0x8, consumed the cycle it appears.
    drive(1'b1, 32'h8, 1'b1, 1'b0);
    step();
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    check("single_valid", 64'(out_valid), 64'd1);
    check("single_pc", 64'(out_pc), 64'h8);
    check("single_instr", 64'(out_instr), 64'h0020_0093);
    step();
    check("single_drained", 64'(out_valid), 64'd0);

    // Fill to full, overflow on a fifth request, then drain in order.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(i * 4), 1'b0, 1'b0);
      step();
    end
    check("fill_full", 64'(full), 64'd1);
    drive(1'b1, 32'h10, 1'b0, 1'b0);
    step();
    check("ovf_set", 64'(overflow), 64'd1);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check("drain_pc", 64'(out_pc), 64'(i * 4));
      step();
    end
    check("drain_empty", 64'(out_valid), 64'd0);

    // Push and pop together at full across pointer wrap.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h20 + 32'(i * 4), 1'b0, 1'b0);
      step();
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h30 + 32'(i * 4), 1'b1, 1'b0);
      step();
      check("wrap_full", 64'(full), 64'd1);
      check("wrap_head", 64'(out_pc), 64'h24 + 64'(i * 4));
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check("wrap_drain_pc", 64'(out_pc), 64'h2C + 64'(i * 4));
      step();
    end

    // Misaligned fetch: filler instruction, one-cycle error pulse.
    drive(1'b1, 32'h6, 1'b0, 1'b0);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    check("mis_instr", 64'(out_instr), 64'h0000_0013);
    check("mis_pulse", 64'(misalign_err), 64'd1);
    step();
    check("mis_pulse_end", 64'(misalign_err), 64'd0);
    check("mis_hold_pc", 64'(out_pc), 64'h6);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    step();

    // Out-of-range fetch: filler instruction, no error.
    drive(1'b1, 32'h100, 1'b0, 1'b0);
    step();
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    check("oor_instr", 64'(out_instr), 64'h0000_0013);
    check("oor_mis", 64'(misalign_err), 64'd0);
    step();

    // Flush with three entries queued and a same-cycle request.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h40 + 32'(i * 4), 1'b0, 1'b0);
      step();
    end
    drive(1'b1, 32'h50, 1'b1, 1'b1);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    check("flush_valid", 64'(out_valid), 64'd0);
    check("flush_full", 64'(full), 64'd0);
    check("flush_ovf_kept", 64'(overflow), 64'd1);

    // Mixed traffic, checked by the model on every cycle.
    for (int i = 0; i < 60; i++) begin
      drive(1'($urandom_range(0, 1)), 32'($urandom_range(0, 160)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0));
      step();
    end

    // Asynchronous reset mid-stream, observed without a clock edge.
    drive(1'b1, 32'h8, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'hC, 1'b0, 1'b0);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    #1 rst = 1'b1;
    #1 check_reset_values("async_rst");
    step();
    #1 rst = 1'b0;
    drive(1'b1, 32'h4, 1'b0, 1'b0);
    step();
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    check("post_rst_valid", 64'(out_valid), 64'd1);
    check("post_rst_pc", 64'(out_pc), 64'h4);
    check("post_rst_instr", 64'(out_instr), 64'h0010_0093);
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_queue.md
IF_FETCH_QUEUE -- requirements
Module: if_fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4: fetch-queue entries, power of two.
REQ-002 SHALL have parameter ROM_WORDS, default 32: instruction ROM words.
REQ-003 SHALL have parameter NOP_INSTR, default 32'h0000_0013: filler instruction.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge; all state in this domain.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port pc  input  32  fetch address from the PC stage.
REQ-007 SHALL have port pc_valid  input  1  pc is a fetch request this cycle.
REQ-008 SHALL have port full  output  1  queue holds DEPTH entries; stall hint upstream.
REQ-009 SHALL have port flush  input  1  discard all queued entries.
REQ-010 SHALL have port out_valid  output  1  head entry available.
REQ-011 SHALL have port out_ready  input  1  consumer accepts head entry.
REQ-012 SHALL have port out_pc  output  32  PC of head entry.
REQ-013 SHALL have port out_instr  output  32  instruction of head entry.
REQ-014 SHALL have port misalign_err  output  1  one-cycle pulse: misaligned push.
REQ-015 SHALL have port overflow  output  1  sticky: a request was dropped.

Function
REQ-016 SHALL look up ROM combinationally at word index pc[6:2] in the push cycle; pc >= ROM_WORDS*4 yields NOP_INSTR.
REQ-017 SHALL hold addi x1,x0,i in ROM word i: 32'h0000_0093 | (i << 20).
REQ-018 SHALL push {pc, instr} when pc_valid=1, flush=0, and (count < DEPTH or pop this cycle).
REQ-019 SHALL pop when out_valid=1 and out_ready=1.
REQ-020 SHALL present a pushed entry on out_* the cycle after the push edge: latency 1, registered outputs, no fall-through.
REQ-021 SHALL keep count unchanged on simultaneous push and pop, including at count=DEPTH and at count=1.
REQ-022 SHALL wrap read and write pointers modulo DEPTH; count ranges 0..DEPTH.
REQ-023 SHALL assert full iff count == DEPTH and out_valid iff count != 0, both decoded from registered count.
REQ-024 SHALL, when pc_valid=1, full=1, and no pop, drop the request and set overflow to 1; overflow holds until reset.
REQ-025 SHALL, when pc[1:0] != 0 on an accepted push, store NOP_INSTR as instr and pulse misalign_err high for exactly the cycle after the push edge.
REQ-026 SHALL, on flush=1, set count, pointers, and out_valid to 0 at the next edge; the same-cycle push and pop are ignored; overflow is unaffected.
REQ-027 SHALL keep out_pc and out_instr stable while out_valid=1 and out_ready=0.

Reset
REQ-028 SHALL, while rst=1, immediately force count=0, pointers=0, out_valid=0, full=0, out_pc=0, out_instr=NOP_INSTR, misalign_err=0, and overflow=0, independent of clk.
REQ-029 SHALL, on rst asserted mid-operation, lose all queued entries; the first push is accepted at the first rising edge with rst=0.
REQ-030 SHALL leave storage array contents unreset; only control state and outputs are reset.

Structure
REQ-031 SHALL take NOP_INSTR, the addi encoding constants, and the {pc, instr} entry struct from shared package fetch_pkg.
REQ-032 SHALL place the ROM in sub-module instr_rom (ports: addr[31:0] in, instr[31:0] out; purely combinational).
REQ-033 SHALL keep queue control (pointers, count, flags) in if_fetch_queue; no further sub-modules.

Verification
REQ-034 SHALL cover: reset release, pc=0x8, pc_valid=1 for one cycle, out_ready=1 -> next cycle out_valid=1, out_pc=0x8, out_instr=0x0020_0093.
REQ-035 SHALL cover: out_ready=0, pushes pc=0x0, 0x4, 0x8, 0xC -> full=1; a 5th push of 0x10 -> overflow=1; then drain -> out_pc sequence 0x0, 0x4, 0x8, 0xC, with 0x10 never seen.
REQ-036 SHALL cover: at full=1, pc_valid=1 and out_ready=1 together for 3 cycles -> full stays 1, count stays 4, FIFO order preserved across pointer wrap.
REQ-037 SHALL cover: pc=0x6 pushed -> out_instr=0x0000_0013, misalign_err high for exactly 1 cycle.
REQ-038 SHALL cover: pc=0x100 pushed -> out_instr=0x0000_0013, misalign_err=0.
REQ-039 SHALL cover: with 3 entries queued, flush=1 with pc_valid=1 -> next cycle out_valid=0 and full=0; rst pulse mid-stream -> outputs at reset values during rst, with no clock edge required.
